// File: rtl/tb_result_checker.sv
// Result monitor: snoops data-memory writes to TEST_PORT, checks them against ANSWERS, counts errors, measures run time.
// Outputs registered, one cycle after the accepting edge; no backpressure, a held wen counts once.
module tb_result_checker #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int TEST_PORT = 0,
  parameter int N_CHECK   = 4,
  parameter logic [N_CHECK*DATA_W-1:0] ANSWERS = '0,
  parameter int TIMEOUT   = 50000,
  parameter int DUR_W     = 16,
  parameter int ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic [7:0]        check_idx,
  output logic              finish,
  output logic              pass,
  output logic              timeout
);

  typedef enum logic [1:0] {RUN, DONE, TOUT} state_t;

  state_t            state, state_nxt;
  logic              wen_d;
  logic              accept;
  logic              mismatch;
  logic              last;
  logic [DATA_W-1:0] expected;
  logic [ERR_W-1:0]  err_nxt;
  logic [DUR_W-1:0]  dur_nxt;
  logic [7:0]        idx_nxt;
  logic              pass_nxt;

  // Rising edge of wen only, so a write stretched by a D-cache stall is seen once.
  assign accept   = wen & ~wen_d & (addr == ADDR_W'(TEST_PORT));
  assign mismatch = accept & (data != expected);
  assign last     = accept & (check_idx == 8'(N_CHECK - 1));

  always_comb begin
    expected = '0;
    for (int i = 0; i < N_CHECK; i++) begin
      if (check_idx == 8'(i)) expected = ANSWERS[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = error_num;
    dur_nxt   = duration;
    idx_nxt   = check_idx;
    pass_nxt  = pass;
    if (state == RUN) begin
      if (duration != '1) dur_nxt = duration + DUR_W'(1);
      if (accept) begin
        idx_nxt = check_idx + 8'd1;
        if (mismatch && (error_num != '1)) err_nxt = error_num + ERR_W'(1);
      end
      // The final write beats a watchdog expiring on the same edge.
      if (last) begin
        state_nxt = DONE;
        pass_nxt  = (err_nxt == '0);
      end else if (duration == DUR_W'(TIMEOUT - 1)) begin
        state_nxt = TOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wen_d     <= 1'b0;
      error_num <= '0;
      duration  <= '0;
      check_idx <= '0;
      finish    <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wen_d     <= wen;
      error_num <= err_nxt;
      duration  <= dur_nxt;
      check_idx <= idx_nxt;
      finish    <= (state_nxt != RUN);
      pass      <= pass_nxt;
      timeout   <= (state_nxt == TOUT);
    end
  end

endmodule

// File: doc/tb_result_checker.md
# tb_result_checker

Parametrised simulation-side result monitor for the pipelined MIPS benches. It snoops the data-memory write bus and checks a sequence of N_CHECK expected values written to a designated test-port address. It counts mismatches and measures run duration in clock cycles. It reports pass, fail or timeout through registered flags. The successor of the single-answer pass monitor, it adds multiple checks, error counting, a live duration counter, a timeout watchdog and stall-safe write de-duplication.

## Interface
- ADDR_W, 30, word-address width of the snooped bus
- DATA_W, 32, data width
- TEST_PORT, 0, word address that receives result writes
- N_CHECK, 4, number of expected results (1..255)
- ANSWERS, 0, flattened expected values; entry i = ANSWERS[i*DATA_W +: DATA_W], width N_CHECK*DATA_W
- TIMEOUT, 50000, maximum run cycles before the watchdog fires (≥1, < 2^DUR_W)
- DUR_W, 16, duration counter width
- ERR_W, 8, error counter width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-low reset
- addr  in  ADDR_W  memory write word address
- data  in  DATA_W  memory write data
- wen  in  1  memory write enable; may be held high for many cycles during D-cache stall
- error_num  out  ERR_W  count of mismatching result writes
- duration  out  DUR_W  cycles spent in RUN
- check_idx  out  8  index of the next expected result
- finish  out  1  run complete (DONE or TOUT)
- pass  out  1  finished with all N_CHECK results matching
- timeout  out  1  watchdog fired

## Operation
- FSM states: RUN, DONE, TOUT. Reset enters RUN.
- Write de-dup: register wen_d. An accepted write requires wen & ~wen_d & (addr == TEST_PORT). A wen held high counts once, however long it is held. wen_d resets to 0, so a wen already high at reset release counts in the first cycle.
- Writes to other addresses are ignored, but they still update wen_d.
- RUN, on each posedge:
  - duration increments, saturating at all-ones.
  - On an accepted write, compare data against ANSWERS[check_idx]. On mismatch, error_num increments, saturating at 2^ERR_W-1. Then check_idx increments.
- RUN -> DONE: an accepted write while check_idx == N_CHECK-1.
  - pass = 1 iff error_num after this write's update is 0.
  - check_idx ends at N_CHECK.
- RUN -> TOUT: duration == TIMEOUT-1 at the edge and no DONE transition on that edge.
  - duration ends at TIMEOUT; timeout=1, pass=0.
- DONE and TOUT are terminal:
  - All outputs are frozen and writes are ignored.
  - Only reset leaves these states.
- Simultaneous final accepted write and timeout edge: DONE wins and timeout stays 0.
- finish = 1 in DONE or TOUT.
- Compare width is DATA_W exactly, no sign extension.

## Timing
- Reset values: error_num=0, duration=0, check_idx=0, finish=0, pass=0, timeout=0, wen_d=0, state=RUN.
- Reset is asynchronous and takes effect immediately, including mid-run or after finish.
- All outputs are registered; none is combinational from the inputs.
- An accepted write in cycle k is reflected in error_num and check_idx after the posedge ending cycle k.
- The final accepted write in cycle k asserts finish and pass from cycle k+1.
- duration equals the number of posedges taken in RUN, including the edge that leaves RUN. Example: a final write accepted in the first cycle after reset gives duration=1.
- wen must fall for at least one cycle before another write to the same or a different address is accepted. Back-to-back distinct writes with continuous wen merge into one.

## Test plan
- Correct sequence: N_CHECK=3, ANSWERS={10,20,60} (idx0=10). Single-cycle writes of 10, 20, 60 to addr 0 at cycles 2, 5, 8 -> finish=1 and pass=1 from cycle 9, error_num=0, duration=9, check_idx=3.
- Mismatch: same params, writes 10, 21, 60 -> finish=1, pass=0, error_num=1.
- Stall hold: wen held high 5 cycles on addr 0 with data 10, then low, then writes 20 and 60 -> check_idx advances by 1 during the hold, final pass=1, error_num=0.
- Foreign addresses: interleaved writes to addr 4 and 8 with data 60 -> check_idx, error_num and finish unchanged.
- Timeout: TIMEOUT=20, no test-port writes -> from cycle 20 finish=1, timeout=1, pass=0, duration=20 and stays frozen. Variant: final write accepted on cycle 19 -> DONE, timeout=0.
- Reset mid-run: reset asserted after the first correct write -> all outputs return to 0 asynchronously; after release, the full sequence is required again and passes.
